// File: rtl/dense_feeder.sv
// dense_feeder: sequences paired weight/activation streams into the 9-tap dense datapath in chunks,
// accumulates the per-chunk MAC results of each neuron and emits one saturated result per neuron.
// Build option: define DENSE_RELU_EN to clamp negative neuron results to zero before output.
module dense_feeder #(
    parameter int DATA_W  = 16,
    parameter int FILT_W  = 16,
    parameter int ADDR_W  = 10,
    parameter int TAPS    = 9,
    parameter int MAC_LAT = 2,
    parameter int ACC_W   = 32,
    parameter int LEN_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start_i,
    input  logic [LEN_W-1:0]  cfg_in_len_i,
    input  logic [LEN_W-1:0]  cfg_num_neurons_i,
    input  logic              w_valid_i,
    output logic              w_ready_o,
    input  logic [FILT_W-1:0] w_data_i,
    input  logic              a_valid_i,
    output logic              a_ready_o,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              shifting_filter_o,
    output logic [FILT_W-1:0] input_filter_o,
    output logic              shifting_line_o,
    output logic [DATA_W-1:0] input_line_o,
    output logic              line_buffer_reset_o,
    output logic [ADDR_W-1:0] row_length_o,
    output logic [7:0]        dense_valid_o,
    input  logic [DATA_W-1:0] out_dense_data_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [DATA_W-1:0] res_data_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CLR  = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_PAD  = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_ACC  = 3'd5;
    localparam logic [2:0] S_OUT  = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [LEN_W-1:0]  n_q, n_d;
    logic [LEN_W-1:0]  neur_q, neur_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        dv_q, dv_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0]  rem_left;
    logic              pair_fire;
    logic              acc_ovf;
    logic [DATA_W-1:0] acc_sat;
    logic [DATA_W-1:0] res_val;

    // Length of the next chunk: a full TAPS chunk or whatever inputs remain.
    function automatic logic [7:0] chunk_len(input logic [LEN_W-1:0] r);
        return (r > LEN_W'(TAPS)) ? 8'(TAPS) : 8'(r);
    endfunction

    assign pair_fire = (state_q == S_LOAD) && w_valid_i && a_valid_i;
    assign rem_left  = rem_q - LEN_W'(dv_q);
    assign acc_ovf   = acc_q[ACC_W-1:DATA_W-1] != {(ACC_W-DATA_W+1){acc_q[ACC_W-1]}};
    assign acc_sat   = acc_ovf ? {acc_q[ACC_W-1], {(DATA_W-1){~acc_q[ACC_W-1]}}} : acc_q[DATA_W-1:0];
`ifdef DENSE_RELU_EN
    assign res_val   = acc_q[ACC_W-1] ? '0 : acc_sat;
`else
    assign res_val   = acc_sat;
`endif

    assign w_ready_o           = pair_fire;
    assign a_ready_o           = pair_fire;
    assign shifting_filter_o   = pair_fire || (state_q == S_PAD);
    assign shifting_line_o     = pair_fire || (state_q == S_PAD);
    assign input_filter_o      = pair_fire ? w_data_i : '0;
    assign input_line_o        = pair_fire ? a_data_i : '0;
    assign line_buffer_reset_o = state_q == S_CLR;
    assign row_length_o        = ADDR_W'(TAPS);
    assign dense_valid_o       = dv_q;
    assign res_valid_o         = state_q == S_OUT;
    assign res_data_o          = (state_q == S_OUT) ? res_val : '0;
    assign busy_o              = state_q != S_IDLE;
    assign done_o              = state_q == S_DONE;

    // Next-state logic: chunk sequencing, per-chunk accumulation and per-neuron hand-off.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        neur_d  = neur_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        dv_d    = dv_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: if (cfg_start_i) begin
                n_d     = cfg_in_len_i;
                neur_d  = cfg_num_neurons_i;
                rem_d   = cfg_in_len_i;
                acc_d   = '0;
                dv_d    = chunk_len(cfg_in_len_i);
                state_d = (cfg_in_len_i == '0 || cfg_num_neurons_i == '0) ? S_DONE : S_CLR;
            end
            S_CLR: begin
                cnt_d   = '0;
                state_d = S_LOAD;
            end
            S_LOAD: if (pair_fire) begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q + 8'd1 == dv_q) begin
                    state_d = (dv_q < 8'(TAPS)) ? S_PAD : S_WAIT;
                    cnt_d   = (dv_q < 8'(TAPS)) ? cnt_q + 8'd1 : '0;
                end
            end
            S_PAD: begin
                cnt_d   = (cnt_q == 8'(TAPS - 1)) ? '0 : cnt_q + 8'd1;
                state_d = (cnt_q == 8'(TAPS - 1)) ? S_WAIT : S_PAD;
            end
            S_WAIT: begin
                cnt_d   = cnt_q + 8'd1;
                state_d = (cnt_q == 8'(MAC_LAT - 1)) ? S_ACC : S_WAIT;
            end
            S_ACC: begin
                acc_d   = acc_q + {{(ACC_W-DATA_W){out_dense_data_i[DATA_W-1]}}, out_dense_data_i};
                rem_d   = rem_left;
                dv_d    = (rem_left == '0) ? dv_q : chunk_len(rem_left);
                state_d = (rem_left == '0) ? S_OUT : S_CLR;
            end
            S_OUT: if (res_ready_i) begin
                if (neur_q == LEN_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    neur_d  = neur_q - LEN_W'(1);
                    rem_d   = n_q;
                    dv_d    = chunk_len(n_q);
                    acc_d   = '0;
                    state_d = S_CLR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            neur_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            dv_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            neur_q  <= neur_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            dv_q    <= dv_d;
            acc_q   <= acc_d;
        end
    end
endmodule
